// File: rtl/bus_event_fifo_io_pkg.sv
// Register map, bit positions and reset values shared by the event FIFO
// peripheral and its storage sub-module.
package bus_event_fifo_io_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'd0;
    localparam logic [7:0] OFF_THRESH = 8'd1;
    localparam logic [7:0] OFF_STATUS = 8'd2;
    localparam logic [7:0] OFF_COUNT  = 8'd3;
    localparam logic [7:0] OFF_POP    = 8'd4;
    localparam logic [7:0] OFF_DATA0  = 8'd5;

    localparam int unsigned CTRL_CAP_EN_BIT = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned CTRL_FLUSH_BIT  = 2;

    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;

    localparam logic [7:0] CTRL_RST   = 8'h03;
    localparam logic [7:0] THRESH_RST = 8'h01;

    // A programmed threshold of zero behaves as one.
    function automatic logic [7:0] thresh_eff(input logic [7:0] t);
        return (t == 8'd0) ? 8'd1 : t;
    endfunction

endpackage

// File: rtl/bus_event_fifo_io_fifo.sv
// Synchronous FIFO holding whole event packets; flush has priority over
// push/pop, and a push into a full FIFO is accepted only alongside a pop.
module sync_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head_c,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    count_next_c,
    output logic             full,
    output logic             empty,
    output logic             push_ok_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             pop_ok_c;

    // Accept/qualify this cycle's requests against the current occupancy.
    always_comb begin
        pop_ok_c     = pop && !empty && !flush;
        push_ok_c    = push && !flush && (!full || pop_ok_c);
        count_next_c = count;
        if (flush) begin
            count_next_c = '0;
        end else begin
            count_next_c = count + CW'(push_ok_c) - CW'(pop_ok_c);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                rd_ptr <= rd_ptr + AW'(pop_ok_c);
                wr_ptr <= wr_ptr + AW'(push_ok_c);
            end
            count <= count_next_c;
            full  <= (count_next_c == CW'(DEPTH));
            empty <= (count_next_c == '0);
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign head_c = mem[rd_ptr];

endmodule

// File: rtl/bus_event_fifo_io.sv
// Memory-mapped event buffer on the 8-bit processor bus: packet FIFO with
// occupancy/overflow status, registered read port and a threshold interrupt.
module bus_event_fifo_io
    import bus_event_fifo_io_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR   = 8'hA0,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ENTRY_BYTES = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     EVT_VALID,
    input  logic [8*ENTRY_BYTES-1:0] EVT_DATA,
    inout  wire  [7:0]               BUS_DATA,
    input  logic [7:0]               BUS_ADDR,
    input  logic                     BUS_WE,
    output logic                     BUS_INTERRUPT_RAISE,
    input  logic                     BUS_INTERRUPT_ACK
);

    localparam int unsigned W   = 8 * ENTRY_BYTES;
    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned WIN = 5 + ENTRY_BYTES;

    logic          cap_en;
    logic          irq_en;
    logic [7:0]    thresh;
    logic          ovf;
    logic          irq;
    logic [7:0]    rd_q;
    logic          bus_oe;

    logic [7:0]    offset_c;
    logic          in_win_c;
    logic          wr_c;
    logic          rd_c;
    logic          flush_c;
    logic          pop_c;
    logic          push_c;
    logic          ovf_set_c;
    logic          irq_set_c;
    logic [7:0]    rd_mux_c;

    logic [W-1:0]  head_c;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next_c;
    logic          full;
    logic          empty;
    logic          push_ok_c;

    // Address decode and strobe qualification.
    always_comb begin
        offset_c  = BUS_ADDR - BASE_ADDR;
        in_win_c  = (BUS_ADDR >= BASE_ADDR) && (offset_c < 8'(WIN));
        wr_c      = BUS_WE && in_win_c;
        rd_c      = !BUS_WE && in_win_c;
        flush_c   = wr_c && (offset_c == OFF_CTRL) && BUS_DATA[CTRL_FLUSH_BIT];
        pop_c     = wr_c && (offset_c == OFF_POP);
        push_c    = EVT_VALID && cap_en;
        ovf_set_c = push_c && !push_ok_c && !flush_c;
        irq_set_c = push_ok_c && irq_en &&
                    (8'(count_next_c) >= thresh_eff(thresh));
    end

    sync_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W),
        .CW    (CW)
    ) u_fifo (
        .CLK          (CLK),
        .RESET        (RESET),
        .push         (push_c),
        .pop          (pop_c),
        .flush        (flush_c),
        .wdata        (EVT_DATA),
        .head_c       (head_c),
        .count        (count),
        .count_next_c (count_next_c),
        .full         (full),
        .empty        (empty),
        .push_ok_c    (push_ok_c)
    );

    // Read mux over the current (pre-update) register and FIFO state.
    always_comb begin
        rd_mux_c = 8'h00;
        case (offset_c)
            OFF_CTRL: begin
                rd_mux_c[CTRL_CAP_EN_BIT] = cap_en;
                rd_mux_c[CTRL_IRQ_EN_BIT] = irq_en;
            end
            OFF_THRESH: rd_mux_c = thresh;
            OFF_STATUS: begin
                rd_mux_c[STAT_EMPTY_BIT] = empty;
                rd_mux_c[STAT_FULL_BIT]  = full;
                rd_mux_c[STAT_OVF_BIT]   = ovf;
            end
            OFF_COUNT: rd_mux_c = 8'(count);
            default: begin
                for (int unsigned k = 0; k < ENTRY_BYTES; k++) begin
                    if (offset_c == (OFF_DATA0 + 8'(k)) && !empty) begin
                        rd_mux_c = head_c[8*k +: 8];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cap_en <= CTRL_RST[CTRL_CAP_EN_BIT];
            irq_en <= CTRL_RST[CTRL_IRQ_EN_BIT];
            thresh <= THRESH_RST;
        end else begin
            if (wr_c && (offset_c == OFF_CTRL)) begin
                cap_en <= BUS_DATA[CTRL_CAP_EN_BIT];
                irq_en <= BUS_DATA[CTRL_IRQ_EN_BIT];
            end
            if (wr_c && (offset_c == OFF_THRESH)) begin
                thresh <= BUS_DATA;
            end
        end
    end

    // Sticky overflow; a new overflow wins over a same-cycle clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ovf <= 1'b0;
        end else if (ovf_set_c) begin
            ovf <= 1'b1;
        end else if (wr_c && (offset_c == OFF_STATUS) && BUS_DATA[STAT_OVF_BIT]) begin
            ovf <= 1'b0;
        end
    end

    // Interrupt latch; a qualifying push wins over a same-cycle acknowledge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            irq <= 1'b0;
        end else if (irq_set_c) begin
            irq <= 1'b1;
        end else if (BUS_INTERRUPT_ACK) begin
            irq <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_q   <= 8'h00;
            bus_oe <= 1'b0;
        end else begin
            bus_oe <= rd_c;
            if (rd_c) begin
                rd_q <= rd_mux_c;
            end
        end
    end

    assign BUS_DATA            = bus_oe ? rd_q : 8'bz;
    assign BUS_INTERRUPT_RAISE = irq;

endmodule

// File: tb/tb_bus_event_fifo_io.sv
// Directed and randomized bench for bus_event_fifo_io against a queue-based
// reference model of the register window and packet FIFO.
module tb_bus_event_fifo_io;

    localparam logic [7:0]  BASE  = 8'hA0;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned EB    = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          EVT_VALID;
    logic [31:0]   EVT_DATA;
    logic [7:0]    BUS_ADDR;
    logic          BUS_WE;
    logic          ACK;
    wire           RAISE;
    wire  [7:0]    BUS_DATA;
    logic          tb_oe;
    logic [7:0]    tb_drv;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mq[$];
    bit          m_cap, m_irqen, m_ovf, m_irq;
    logic [7:0]  m_thr;

    assign BUS_DATA = tb_oe ? tb_drv : 8'bz;
    always #5 CLK = ~CLK;

    bus_event_fifo_io #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .ENTRY_BYTES(EB)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .EVT_VALID           (EVT_VALID),
        .EVT_DATA            (EVT_DATA),
        .BUS_DATA            (BUS_DATA),
        .BUS_ADDR            (BUS_ADDR),
        .BUS_WE              (BUS_WE),
        .BUS_INTERRUPT_RAISE (RAISE),
        .BUS_INTERRUPT_ACK   (ACK)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input logic [7:0] a);
        logic [7:0] off;
        off = a - BASE;
        return (a >= BASE) && (off < 8'(5 + EB));
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cap = 1'b1; m_irqen = 1'b1; m_ovf = 1'b0; m_irq = 1'b0;
        m_thr = 8'd1;
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        logic [7:0]  off;
        logic [31:0] h;
        off = a - BASE;
        case (off)
            8'd0: return {6'b0, m_irqen, m_cap};
            8'd1: return m_thr;
            8'd2: return {5'b0, m_ovf, mq.size() == DEPTH, mq.size() == 0};
            8'd3: return 8'(mq.size());
            8'd4: return 8'h00;
            default: begin
                if (mq.size() == 0) return 8'h00;
                h = mq[0];
                h = h >> (8 * (int'(off) - 5));
                return h[7:0];
            end
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently applied, then clock the DUT.
    task automatic step();
        bit         w, flush, pop, push, stored, popped, ovfset;
        logic [7:0] off;
        int         thr;
        w      = BUS_WE && in_win(BUS_ADDR);
        off    = BUS_ADDR - BASE;
        flush  = w && off == 8'd0 && tb_drv[2];
        pop    = w && off == 8'd4;
        push   = EVT_VALID && m_cap;
        stored = 0; popped = 0; ovfset = 0;
        if (flush) begin
            mq.delete();
        end else begin
            popped = pop && mq.size() > 0;
            if (push) begin
                if (mq.size() < DEPTH || popped) stored = 1;
                else ovfset = 1;
            end
            if (popped) void'(mq.pop_front());
            if (stored) mq.push_back(EVT_DATA);
        end
        thr = (m_thr == 0) ? 1 : int'(m_thr);
        if (stored && m_irqen && mq.size() >= thr) m_irq = 1;
        else if (ACK) m_irq = 0;
        if (w && off == 8'd0) begin m_cap = tb_drv[0]; m_irqen = tb_drv[1]; end
        if (w && off == 8'd1) m_thr = tb_drv;
        if (w && off == 8'd2 && tb_drv[2]) m_ovf = 0;
        if (ovfset) m_ovf = 1;
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        BUS_ADDR = a; BUS_WE = 1'b0; tb_oe = 1'b0;
        step();
        v = BUS_DATA;
    endtask

    task automatic rdc(input string tag, input logic [7:0] a);
        logic [7:0] exp, v;
        exp = model_read(a);
        rd(a, v);
        check(tag, v, exp);
    endtask

    task automatic rdk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] v;
        rd(a, v);
        check(tag, v, exp);
    endtask

    // Idle cycle first so the DUT has released the bus before we drive it.
    task automatic wr(input logic [7:0] a, input logic [7:0] d,
                      input bit ev = 1'b0, input logic [31:0] ed = 32'h0);
        logic ev_save;
        ev_save = EVT_VALID;
        EVT_VALID = 1'b0;
        BUS_ADDR = 8'h00; BUS_WE = 1'b0; tb_oe = 1'b0;
        step();
        BUS_ADDR = a; BUS_WE = 1'b1; tb_drv = d; tb_oe = 1'b1;
        EVT_VALID = ev; EVT_DATA = ed;
        step();
        BUS_WE = 1'b0; tb_oe = 1'b0; BUS_ADDR = 8'h00;
        EVT_VALID = ev_save;
    endtask

    task automatic push(input logic [31:0] d, input bit ack = 1'b0);
        BUS_ADDR = 8'h00; BUS_WE = 1'b0;
        EVT_VALID = 1'b1; EVT_DATA = d; ACK = ack;
        step();
        EVT_VALID = 1'b0; ACK = 1'b0;
    endtask

    task automatic hiz(input string tag);
        tb_oe = 1'b1; tb_drv = 8'h5A; #1;
        check({tag, "_5a"}, BUS_DATA, 8'h5A);
        tb_drv = 8'hA5; #1;
        check({tag, "_a5"}, BUS_DATA, 8'hA5);
        tb_oe = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int         op;
        RESET = 1'b1; EVT_VALID = 1'b0; EVT_DATA = '0; BUS_ADDR = 8'h00;
        BUS_WE = 1'b0; ACK = 1'b0; tb_oe = 1'b0; tb_drv = 8'h00;
        model_reset();
        #2 RESET = 1'b0;
        #1 hiz("hiz_rst");
        repeat (2) @(posedge CLK);
        @(negedge CLK) RESET = 1'b1;
        @(posedge CLK); #1;

        // Reset values
        rdk("rst_ctrl", BASE + 8'd0, 8'h03);
        rdk("rst_thresh", BASE + 8'd1, 8'h01);
        rdk("rst_status", BASE + 8'd2, 8'h01);
        rdk("rst_count", BASE + 8'd3, 8'h00);
        check("rst_raise", RAISE, 1'b0);
        BUS_ADDR = 8'h50; step();
        hiz("hiz_out");

        // Byte order and pop
        push(32'h11223344);
        check("raise_thr1", RAISE, 1'b1);
        push(32'h55667788);
        rdk("d0", BASE + 8'd5, 8'h44);
        rdk("d1", BASE + 8'd6, 8'h33);
        rdk("d2", BASE + 8'd7, 8'h22);
        rdk("d3", BASE + 8'd8, 8'h11);
        rdk("cnt2", BASE + 8'd3, 8'h02);
        wr(BASE + 8'd4, 8'h00);
        rdk("d0_pop", BASE + 8'd5, 8'h88);
        rdk("cnt1", BASE + 8'd3, 8'h01);

        // Overflow on the 9th push
        wr(BASE + 8'd0, 8'h07);
        rdk("flush_cnt", BASE + 8'd3, 8'h00);
        for (int i = 0; i < 9; i++) push(32'h1000_0000 + 32'(i));
        rdk("full_cnt", BASE + 8'd3, 8'h08);
        rdk("full_stat", BASE + 8'd2, 8'h06);
        for (int i = 0; i < 8; i++) begin
            rdk("drain_order", BASE + 8'd5, 8'(i));
            wr(BASE + 8'd4, 8'h00);
        end
        rdk("drained_stat", BASE + 8'd2, 8'h05);
        wr(BASE + 8'd2, 8'h04);
        rdk("ovf_clr", BASE + 8'd2, 8'h01);

        // Threshold interrupt
        ACK = 1'b1; step(); ACK = 1'b0;
        check("irq_acked", RAISE, 1'b0);
        wr(BASE + 8'd1, 8'h03);
        push(32'hA1); push(32'hA2);
        check("irq_below", RAISE, 1'b0);
        push(32'hA3);
        check("irq_at_thr", RAISE, 1'b1);
        ACK = 1'b1; step(); ACK = 1'b0;
        check("irq_ack", RAISE, 1'b0);
        push(32'hA4, 1'b1);
        check("irq_set_over_ack", RAISE, 1'b1);
        wr(BASE + 8'd0, 8'h01);
        check("irq_hold_en0", RAISE, 1'b1);
        ACK = 1'b1; step(); ACK = 1'b0;
        wr(BASE + 8'd0, 8'h07);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) push(32'h20 + 32'(i));
        wr(BASE + 8'd4, 8'h00, 1'b1, 32'h28);
        rdk("pp_cnt", BASE + 8'd3, 8'h08);
        rdk("pp_stat", BASE + 8'd2, 8'h02);
        for (int i = 0; i < 8; i++) begin
            rdk("pp_order", BASE + 8'd5, 8'h21 + 8'(i));
            wr(BASE + 8'd4, 8'h00);
        end

        // Flush concurrent with push keeps OVF as it was
        for (int i = 0; i < 9; i++) push(32'h30 + 32'(i));
        wr(BASE + 8'd0, 8'h07, 1'b1, 32'hEE);
        rdk("fl_cnt", BASE + 8'd3, 8'h00);
        rdk("fl_stat", BASE + 8'd2, 8'h05);
        wr(BASE + 8'd2, 8'h04);

        // Capture disabled, pop on empty
        wr(BASE + 8'd0, 8'h02);
        push(32'h1); push(32'h2); push(32'h3);
        rdk("cap0_cnt", BASE + 8'd3, 8'h00);
        wr(BASE + 8'd4, 8'h00);
        rdk("pope_cnt", BASE + 8'd3, 8'h00);
        rdk("pope_stat", BASE + 8'd2, 8'h01);
        wr(BASE + 8'd0, 8'h03);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            EVT_VALID = ($urandom_range(0, 1) == 0);
            EVT_DATA  = $urandom;
            ACK       = ($urandom_range(0, 7) == 0);
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                rdc("rnd_rd", BASE + 8'($urandom_range(0, 4 + EB)));
            end else if (op <= 6) begin
                wr(BASE + 8'd4, 8'h00, $urandom_range(0, 1) == 0, $urandom);
            end else if (op == 7) begin
                wr(BASE + 8'd1, 8'($urandom_range(0, 9)));
            end else if (op == 8) begin
                d = 8'h00;
                d[0] = ($urandom_range(0, 4) != 0);
                d[1] = ($urandom_range(0, 1) == 0);
                d[2] = ($urandom_range(0, 7) == 0);
                wr(BASE + 8'd0, d);
            end else begin
                wr(BASE + 8'd2, 8'($urandom));
            end
            check("rnd_raise", RAISE, m_irq);
        end
        EVT_VALID = 1'b0; ACK = 1'b0;

        // Asynchronous reset in the middle of a driven read
        push(32'hCAFE);
        rdk("pre_rst_ctrl", BASE + 8'd0, model_read(BASE));
        #2 RESET = 1'b0;
        #1 hiz("hiz_async");
        model_reset();
        BUS_ADDR = 8'h00;
        @(negedge CLK) RESET = 1'b1;
        @(posedge CLK); #1;
        rdk("post_rst_cnt", BASE + 8'd3, 8'h00);
        rdk("post_rst_ctrl", BASE + 8'd0, 8'h03);
        check("post_rst_raise", RAISE, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
